// File: rtl/mod503_pkg.sv
// Shared definitions for the mod-503 rebuild datapath.
// Holds the digit/carry widths, the output/quotient sizes, the modulus and
// the controller state encoding. 503 = 2^9 - 9, so one radix-512 digit of Q
// times 503 is a shift-subtract plus carry.
package mod503_pkg;

  localparam int unsigned DW  = 9;          // digit width
  localparam int unsigned ND  = 23;         // output digits
  localparam int unsigned QW  = 192;        // quotient width
  localparam int unsigned XW  = 200;        // rebuilt word width
  localparam int unsigned MOD = 503;        // modulus
  localparam int unsigned RW  = DW * ND;    // result register width (207)
  localparam int unsigned QPW = DW * (ND - 1); // zero-padded Q width (198)
  localparam int unsigned CW  = DW + 1;     // carry width
  localparam int unsigned AW  = 19;         // MAC accumulator width

  typedef logic [DW-1:0] digit_t;
  typedef logic [CW-1:0] carry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/x_200_mod_503_rebuild_if.sv
// Request/response bundle for the mod-503 rebuilder.
//   in_valid/in_ready  : request handshake carrying Q (quotient) and R (residue)
//   out_valid/out_ready: response handshake carrying X, ovf, r_err
// master: request source / result consumer.  slave: the rebuilder.
interface x_200_mod_503_rebuild_if;
  import mod503_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] Q;
  logic [DW-1:0] R;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] X;
  logic          ovf;
  logic          r_err;

  modport master (
    output in_valid, Q, R, out_ready,
    input  in_ready, out_valid, X, ovf, r_err
  );

  modport slave (
    input  in_valid, Q, R, out_ready,
    output in_ready, out_valid, X, ovf, r_err
  );

endinterface

// File: rtl/mod503_digit_mac.sv
// One digit step of X = Q*503 + R, combinational.
//   qd        : current radix-512 digit of Q
//   carry_in  : carry from the previous digit (initially R)
//   digit     : result digit, acc[8:0]
//   carry_out : acc[18:9], never exceeds 503
// qd*503 is formed as qd*512 - qd*8 - qd, so no multiplier is needed.
module mod503_digit_mac
  import mod503_pkg::*;
(
  input  digit_t qd,
  input  carry_t carry_in,
  output digit_t digit,
  output carry_t carry_out
);

  logic [AW-1:0] qx;
  logic [AW-1:0] acc;

  always_comb begin
    qx  = AW'(qd);
    acc = (qx << DW) - (qx << 3) - qx + AW'(carry_in);
  end

  assign digit     = acc[DW-1:0];
  assign carry_out = acc[AW-1:DW];

endmodule

// File: rtl/x_200_mod_503_rebuild.sv
// Rebuilds X = Q*503 + R digit-serially, one 9-bit digit of Q per clock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of x_200_mod_503_rebuild_if
//                request  Q[191:0], R[8:0]   (in_valid/in_ready)
//                response X[199:0], ovf, r_err (out_valid/out_ready)
// Result digits enter the top of a 207-bit shift register, so after 23 steps
// digit 0 sits at the bottom. X is a separate register so it keeps the last
// result while the next one is being built.
module x_200_mod_503_rebuild
  import mod503_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  x_200_mod_503_rebuild_if.slave  bus
);

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [QPW-1:0] q_sr_q, q_sr_d;
  carry_t         carry_q, carry_d;
  logic [RW-1:0]  res_q, res_d;
  logic [XW-1:0]  x_q, x_d;
  logic           ovf_q, ovf_d;
  logic           r_err_q, r_err_d;
  logic           out_valid_q, out_valid_d;

  digit_t         mac_digit;
  carry_t         mac_carry;

  // Q is shifted right each step, so digit 22 reads the zero padding.
  mod503_digit_mac u_mac (
    .qd        (q_sr_q[DW-1:0]),
    .carry_in  (carry_q),
    .digit     (mac_digit),
    .carry_out (mac_carry)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_sr_d      = q_sr_q;
    carry_d     = carry_q;
    res_d       = res_q;
    x_d         = x_q;
    ovf_d       = ovf_q;
    r_err_d     = r_err_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          q_sr_d  = QPW'(bus.Q);
          carry_d = CW'(bus.R);
          r_err_d = (bus.R >= DW'(MOD));
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {mac_digit, res_q[RW-1:DW]};
        q_sr_d  = q_sr_q >> DW;
        carry_d = mac_carry;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(ND - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle publishes the result; afterwards wait for out_ready.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          x_d         = res_q[XW-1:0];
          ovf_d       = |res_q[RW-1:XW];
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_sr_q      <= '0;
      carry_q     <= '0;
      res_q       <= '0;
      x_q         <= '0;
      ovf_q       <= 1'b0;
      r_err_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_sr_q      <= q_sr_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      x_q         <= x_d;
      ovf_q       <= ovf_d;
      r_err_q     <= r_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.X         = x_q;
  assign bus.ovf       = ovf_q;
  assign bus.r_err     = r_err_q;

endmodule

// File: tb/tb_x_200_mod_503_rebuild.sv
// Directed and randomised checks for x_200_mod_503_rebuild.
// Expected X comes from direct wide multiplication Q*503 + R.
module tb_x_200_mod_503_rebuild;
  import mod503_pkg::*;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;

  x_200_mod_503_rebuild_if bus ();

  x_200_mod_503_rebuild dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [207:0] model(input logic [QW-1:0] q, input logic [DW-1:0] r);
    return 208'(q) * 208'd503 + 208'(r);
  endfunction

  // Runs one request; hold = cycles to keep out_ready low in DONE.
  task automatic txn(input logic [QW-1:0] q, input logic [DW-1:0] r,
                     input int unsigned hold, input string tag);
    logic [207:0] exp;
    logic [XW-1:0] xg;
    int unsigned lat;
    exp = model(q, r);
    bus.Q = q;
    bus.R = r;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_rerr_early"}, 256'(bus.r_err), 256'(r >= 9'd503));
    check({tag, "_ovf_clr"}, 256'(bus.ovf), 256'(0));
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 256'(lat), 256'(24));
    xg = bus.X;
    check({tag, "_x"}, 256'(bus.X), 256'(exp[XW-1:0]));
    check({tag, "_ovf"}, 256'(bus.ovf), 256'(|exp[206:200]));
    check({tag, "_rerr"}, 256'(bus.r_err), 256'(r >= 9'd503));
    check({tag, "_busy"}, 256'(bus.in_ready), 256'(0));
    for (int unsigned i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.Q = ~q;
      bus.R = 9'd1;
      @(posedge clk); #1;
      check({tag, "_hold_x"}, 256'(bus.X), 256'(exp[XW-1:0]));
      check({tag, "_hold_valid"}, 256'(bus.out_valid), 256'(1));
      check({tag, "_hold_ready"}, 256'(bus.in_ready), 256'(0));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 256'(bus.out_valid), 256'(0));
    check({tag, "_idle_ready"}, 256'(bus.in_ready), 256'(1));
    check({tag, "_x_kept"}, 256'(bus.X), 256'(exp[XW-1:0]));
    if (!(|exp[206:200]) && r < 9'd503)
      check({tag, "_reduce"}, 256'(xg % 200'd503), 256'(r));
  endtask

  initial begin
    logic [XW-1:0] all1, qmax, rmax;
    logic [QW-1:0] qr;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.Q = '0;
    bus.R = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 256'(bus.in_ready), 256'(1));
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_x", 256'(bus.X), 256'(0));
    check("rst_ovf", 256'(bus.ovf), 256'(0));
    check("rst_rerr", 256'(bus.r_err), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero input
    txn('0, 9'd0, 0, "zero");
    // Small directed values
    txn(192'd1, 9'd502, 0, "q1_r502");
    check("q1_r502_const", 256'(bus.X), 256'd1005);
    txn(192'h1234, 9'd7, 0, "q1234");
    check("q1234_const", 256'(bus.X), 256'd2343987);

    // Largest Q whose rebuild fits 200 bits, then one past it
    all1 = '1;
    qmax = all1 / 200'd503;
    rmax = all1 % 200'd503;
    txn(qmax[QW-1:0], rmax[DW-1:0], 0, "max");
    check("max_all_ones", 256'(bus.X), 256'(all1));
    check("max_no_ovf", 256'(bus.ovf), 256'(0));
    txn(qmax[QW-1:0], rmax[DW-1:0] + 9'd1, 0, "max_p1");
    check("max_p1_ovf", 256'(bus.ovf), 256'(1));
    check("max_p1_zero", 256'(bus.X), 256'(0));

    // Illegal residues still used in the arithmetic
    txn('0, 9'd503, 0, "r503");
    check("r503_const", 256'(bus.X), 256'd503);
    txn('0, 9'd511, 0, "r511");
    check("r511_const", 256'(bus.X), 256'd511);

    // Backpressure in DONE, then a normal follow-up
    txn(192'hdead_beef_0123_4567, 9'd250, 10, "hold");
    txn(192'd99, 9'd4, 0, "after_hold");
    check("after_hold_const", 256'(bus.X), 256'd49801);

    // Reset mid-computation
    bus.Q = {6{32'ha5a5_5a5a}};
    bus.R = 9'd510;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("abort_rerr_set", 256'(bus.r_err), 256'(1));
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 256'(bus.in_ready), 256'(1));
    check("abort_out_valid", 256'(bus.out_valid), 256'(0));
    check("abort_x", 256'(bus.X), 256'(0));
    check("abort_ovf", 256'(bus.ovf), 256'(0));
    check("abort_rerr", 256'(bus.r_err), 256'(0));
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(192'd5, 9'd3, 0, "post_abort");
    check("post_abort_const", 256'(bus.X), 256'd2518);

    // Random requests
    for (int unsigned i = 0; i < 150; i++) begin
      qr = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (i[1:0] == 2'd1) qr = qr >> $urandom_range(1, 191);
      txn(qr, 9'($urandom_range(0, 502)), 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
